// File: rtl/pgm_tx_linebuf.sv
// PGM text-layer line renderer: fetches 8x8 4bpp tiles for the next
// scanline into one bank of a double-buffered line buffer while the mixer reads the other.
module pgm_tx_linebuf #(
   parameter logic [12:0] TX_BASE = 13'h1000,
   parameter int          WIDTH   = 448
) (
   input  logic        fixed_20m_clk,
   input  logic        reset,
   input  logic        line_start,
   input  logic [7:0]  line,
   input  logic [8:0]  scroll_x,
   input  logic [7:0]  scroll_y,
   input  logic        layer_en,
   output logic [12:0] vram_addr,
   input  logic [15:0] vram_dout,
   output logic [19:0] gfx_addr,
   input  logic [15:0] gfx_dout,
   input  logic [8:0]  pix_x,
   output logic [8:0]  pix_out,
   output logic        busy,
   output logic        overrun
);

   localparam logic [9:0] W10 = 10'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_CODE, S_ATTR, S_G0, S_G1, S_LATCH, S_DRAW
   } state_t;

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;
   logic        wbank_q, wbank_d;
   logic [5:0]  i_q, i_d;
   logic [2:0]  p_q, p_d;
   logic [4:0]  ty_q, ty_d;
   logic [2:0]  fy_q, fy_d;
   logic [5:0]  cx_q, cx_d;
   logic [2:0]  fx_q, fx_d;
   logic [15:0] code_q, code_d;
   logic [6:0]  attr_q, attr_d;
   logic [15:0] g0_q, g0_d;
   logic [15:0] g1_q, g1_d;
   logic [12:0] vram_addr_q, vram_addr_d;
   logic [19:0] gfx_addr_q, gfx_addr_d;
   logic [8:0]  pix_out_q, pix_out_d;

   logic [8:0]  lbuf [2][512];

   logic [7:0]  y;
   logic [5:0]  tx;
   logic [12:0] map_addr;
   logic        flip_y;
   logic [2:0]  row;
   logic [2:0]  src;
   logic [31:0] pix_word;
   logic [3:0]  nib;
   logic [10:0] xpos;
   logic        we;
   logic [8:0]  wdata;

   // Fetch addressing, pixel extraction and line-buffer write strobe
   always_comb begin
      y        = line + scroll_y;
      tx       = cx_q + i_q;
      map_addr = TX_BASE + {1'b0, ty_q, tx, 1'b0};
      // attr only arrives on vram_dout during G0, so bypass it there
      flip_y   = (state_q == S_G0) ? vram_dout[6] : attr_q[6];
      row      = fy_q ^ {3{flip_y}};
      src      = attr_q[5] ? ~p_q : p_q;
      pix_word = {g1_q, g0_q};
      nib      = pix_word[{src, 2'b00} +: 4];
      xpos     = {2'b00, i_q, p_q} - {8'd0, fx_q};
      we       = (state_q == S_DRAW) && !xpos[10] && (xpos[9:0] < W10);
      wdata    = (nib == 4'd0) ? 9'h000 : {attr_q[4:0], nib};

      vram_addr = vram_addr_q;
      gfx_addr  = gfx_addr_q;
      unique case (state_q)
         S_CODE:  vram_addr = map_addr;
         S_ATTR:  vram_addr = map_addr | 13'd1;
         S_G0:    gfx_addr  = {code_q, row, 1'b0};
         S_G1:    gfx_addr  = {code_q, row, 1'b1};
         default: ;
      endcase
   end

   // Tile sequencer next state
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      overrun_d   = 1'b0;
      wbank_d     = wbank_q;
      i_d         = i_q;
      p_d         = p_q;
      ty_d        = ty_q;
      fy_d        = fy_q;
      cx_d        = cx_q;
      fx_d        = fx_q;
      code_d      = code_q;
      attr_d      = attr_q;
      g0_d        = g0_q;
      g1_d        = g1_q;
      vram_addr_d = vram_addr;
      gfx_addr_d  = gfx_addr;

      if (line_start) begin
         overrun_d = busy_q;
         wbank_d   = ~wbank_q;
         i_d       = 6'd0;
         ty_d      = y[7:3];
         fy_d      = y[2:0];
         cx_d      = scroll_x[8:3];
         fx_d      = scroll_x[2:0];
         state_d   = S_CODE;
         busy_d    = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE:  ;
            S_CODE:  state_d = S_ATTR;
            S_ATTR: begin
               code_d  = vram_dout;
               state_d = S_G0;
            end
            S_G0: begin
               attr_d  = vram_dout[6:0];
               state_d = S_G1;
            end
            S_G1: begin
               g0_d    = gfx_dout;
               state_d = S_LATCH;
            end
            S_LATCH: begin
               g1_d    = gfx_dout;
               p_d     = 3'd0;
               state_d = S_DRAW;
            end
            S_DRAW: begin
               p_d = p_q + 3'd1;
               if (p_q == 3'd7) begin
                  if (i_q == 6'd56) begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end else begin
                     i_d     = i_q + 6'd1;
                     state_d = S_CODE;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // Display-side read from the bank finished during the previous line
   always_comb begin
      pix_out_d = 9'h000;
      if (layer_en && ({1'b0, pix_x} < W10))
         pix_out_d = lbuf[~wbank_q][pix_x];
   end

   // Sequencer and output registers
   always_ff @(posedge fixed_20m_clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         wbank_q     <= 1'b0;
         i_q         <= 6'd0;
         p_q         <= 3'd0;
         ty_q        <= 5'd0;
         fy_q        <= 3'd0;
         cx_q        <= 6'd0;
         fx_q        <= 3'd0;
         code_q      <= 16'd0;
         attr_q      <= 7'd0;
         g0_q        <= 16'd0;
         g1_q        <= 16'd0;
         vram_addr_q <= 13'd0;
         gfx_addr_q  <= 20'd0;
         pix_out_q   <= 9'd0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         wbank_q     <= wbank_d;
         i_q         <= i_d;
         p_q         <= p_d;
         ty_q        <= ty_d;
         fy_q        <= fy_d;
         cx_q        <= cx_d;
         fx_q        <= fx_d;
         code_q      <= code_d;
         attr_q      <= attr_d;
         g0_q        <= g0_d;
         g1_q        <= g1_d;
         vram_addr_q <= vram_addr_d;
         gfx_addr_q  <= gfx_addr_d;
         pix_out_q   <= pix_out_d;
      end
   end

   // Line buffer write port; contents survive reset
   always_ff @(posedge fixed_20m_clk) begin
      if (we)
         lbuf[wbank_q][xpos[8:0]] <= wdata;
   end

   assign pix_out = pix_out_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_pgm_tx_linebuf.sv
// Directed bench for pgm_tx_linebuf: hand sequences for timing corners
// plus a table of rendered-pixel vectors.
module tb_pgm_tx_linebuf;

   logic        clk = 1'b0;
   logic        reset;
   logic        line_start;
   logic [7:0]  line;
   logic [8:0]  scroll_x;
   logic [7:0]  scroll_y;
   logic        layer_en;
   logic [12:0] vram_addr;
   logic [15:0] vram_dout;
   logic [19:0] gfx_addr;
   logic [15:0] gfx_dout;
   logic [8:0]  pix_x;
   logic [8:0]  pix_out;
   logic        busy;
   logic        overrun;

   logic [15:0] vram_mem [0:8191];
   logic [15:0] gfx_mem  [0:4095];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pgm_tx_linebuf dut (
      .fixed_20m_clk (clk),
      .reset         (reset),
      .line_start    (line_start),
      .line          (line),
      .scroll_x      (scroll_x),
      .scroll_y      (scroll_y),
      .layer_en      (layer_en),
      .vram_addr     (vram_addr),
      .vram_dout     (vram_dout),
      .gfx_addr      (gfx_addr),
      .gfx_dout      (gfx_dout),
      .pix_x         (pix_x),
      .pix_out       (pix_out),
      .busy          (busy),
      .overrun       (overrun)
   );

   // Memories answer one cycle after the address
   always @(posedge clk) begin
      vram_dout <= vram_mem[vram_addr];
      gfx_dout  <= gfx_mem[gfx_addr[11:0]];
   end

   typedef struct {
      logic [8:0]  sx;
      logic [15:0] attr;
      logic [15:0] g0;
      logic [15:0] g1;
      logic        en;
      logic [8:0]  px;
      logic [8:0]  exp;
   } vec_t;

   vec_t vecs [21];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      line_start = 1'b1;
      step();
      line_start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 2000) begin
         step();
         n++;
      end
      chk("idle_wait", busy, 0);
   endtask

   // Tile 0 gets code 5; the selected row holds g0/g1, the other row a decoy
   task automatic setup(input logic [8:0] sx, input logic [15:0] attr,
                        input logic [15:0] g0, input logic [15:0] g1);
      int r;
      for (int k = 16'h50; k < 16'h60; k++) gfx_mem[k] = 16'hFFFF;
      r = attr[6] ? 7 : 0;
      gfx_mem[16'h50 + 2 * r]     = g0;
      gfx_mem[16'h50 + 2 * r + 1] = g1;
      vram_mem[13'h1000] = 16'h0005;
      vram_mem[13'h1001] = attr;
      scroll_x = sx;
   endtask

   // Render line 0, then swap so the result becomes the display bank
   task automatic render();
      wait_idle();
      pulse();
      repeat (741) step();
      pulse();
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      bit do_render;

      for (int k = 0; k < 8192; k++) vram_mem[k] = 16'h0;
      for (int k = 0; k < 4096; k++) gfx_mem[k] = 16'h0;
      vram_mem[13'h1070] = 16'h0006;
      vram_mem[13'h1071] = 16'h0002;
      gfx_mem[12'h060]   = 16'h4321;

      vecs[0]  = '{9'd0,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd0,   9'h031};
      vecs[1]  = '{9'd0,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd3,   9'h034};
      vecs[2]  = '{9'd0,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd7,   9'h038};
      vecs[3]  = '{9'd0,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd8,   9'h000};
      vecs[4]  = '{9'd0,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd447, 9'h000};
      vecs[5]  = '{9'd0,   16'h0003, 16'h4321, 16'h8765, 1'b0, 9'd0,   9'h000};
      vecs[6]  = '{9'd0,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd448, 9'h000};
      vecs[7]  = '{9'd0,   16'h0063, 16'h4321, 16'h8765, 1'b1, 9'd0,   9'h038};
      vecs[8]  = '{9'd0,   16'h0063, 16'h4321, 16'h8765, 1'b1, 9'd7,   9'h031};
      vecs[9]  = '{9'd0,   16'h0063, 16'h4321, 16'h8765, 1'b1, 9'd3,   9'h035};
      vecs[10] = '{9'd3,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd0,   9'h034};
      vecs[11] = '{9'd3,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd4,   9'h038};
      vecs[12] = '{9'd3,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd445, 9'h021};
      vecs[13] = '{9'd3,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd446, 9'h022};
      vecs[14] = '{9'd3,   16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd447, 9'h023};
      vecs[15] = '{9'd0,   16'h0003, 16'h4301, 16'h8765, 1'b1, 9'd0,   9'h031};
      vecs[16] = '{9'd0,   16'h0003, 16'h4301, 16'h8765, 1'b1, 9'd1,   9'h000};
      vecs[17] = '{9'd0,   16'h0003, 16'h4301, 16'h8765, 1'b1, 9'd2,   9'h033};
      vecs[18] = '{9'd0,   16'hFF9F, 16'h4321, 16'h8765, 1'b1, 9'd0,   9'h1F1};
      vecs[19] = '{9'd504, 16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd8,   9'h031};
      vecs[20] = '{9'd504, 16'h0003, 16'h4321, 16'h8765, 1'b1, 9'd0,   9'h000};

      reset      = 1'b1;
      line_start = 1'b0;
      line       = 8'd0;
      scroll_x   = 9'd0;
      scroll_y   = 8'd0;
      layer_en   = 1'b1;
      pix_x      = 9'd0;
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_vram_addr", vram_addr, 0);
      chk("rst_gfx_addr", gfx_addr, 0);
      reset = 1'b0;
      step();

      // Fetch address sequence for tile 0, then reset mid-DRAW
      setup(9'd0, 16'h0003, 16'h4321, 16'h8765);
      pulse();
      chk("busy_first", busy, 1);
      chk("code_addr", vram_addr, 13'h1000);
      step();
      chk("attr_addr", vram_addr, 13'h1001);
      step();
      chk("g0_addr", gfx_addr, 20'h00050);
      step();
      chk("g1_addr", gfx_addr, 20'h00051);
      step();
      chk("hold_vram", vram_addr, 13'h1001);
      chk("hold_gfx", gfx_addr, 20'h00051);
      repeat (3) step();
      #2 reset = 1'b1;
      #1;
      chk("arst_vram", vram_addr, 0);
      chk("arst_gfx", gfx_addr, 0);
      chk("arst_pix", pix_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_overrun", overrun, 0);
      step();
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (busy) cnt++;
      end
      chk("post_rst_busy", cnt, 0);

      // Flipped tile reads row 7
      setup(9'd0, 16'h0063, 16'h4321, 16'h8765);
      pulse();
      step();
      step();
      chk("flip_g0_addr", gfx_addr, 20'h0005E);
      step();
      chk("flip_g1_addr", gfx_addr, 20'h0005F);

      // Coarse scroll to tx=63 and full busy length
      wait_idle();
      scroll_x = 9'd504;
      pulse();
      chk("wrap_addr", vram_addr, 13'h107E);
      cnt = 1;
      while (busy && cnt < 2000) begin
         step();
         if (busy) cnt++;
      end
      chk("busy_len", cnt, 741);
      chk("no_overrun", overrun, 0);

      // Overrun at cycle 300 restarts at tile 0
      scroll_x = 9'd0;
      pulse();
      repeat (298) step();
      chk("busy_mid", busy, 1);
      pulse();
      chk("overrun_pulse", overrun, 1);
      chk("restart_addr", vram_addr, 13'h1000);
      cnt = 0;
      while (busy && cnt < 2000) begin
         cnt++;
         step();
         if (cnt == 1) chk("overrun_clear", overrun, 0);
      end
      chk("restart_busy_len", cnt, 741);

      // Table of rendered pixels
      for (int v = 0; v < 21; v++) begin
         do_render = (v == 0) ||
                     (vecs[v].sx   != vecs[v-1].sx)   ||
                     (vecs[v].attr != vecs[v-1].attr) ||
                     (vecs[v].g0   != vecs[v-1].g0)   ||
                     (vecs[v].g1   != vecs[v-1].g1);
         if (do_render) begin
            setup(vecs[v].sx, vecs[v].attr, vecs[v].g0, vecs[v].g1);
            render();
         end
         layer_en = vecs[v].en;
         pix_x    = vecs[v].px;
         step();
         chk($sformatf("vec%0d_px%0d", v, vecs[v].px), pix_out, vecs[v].exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pgm_tx_linebuf.md
# pgm_tx_linebuf

Text-layer line renderer for the PGM video path. It consumes the tilemap VRAM export port and a graphics-ROM read port, then renders one 448-pixel scanline of the 8×8, 4 bpp text layer into a double-buffered line buffer. It fetches line N+1 while the downstream mixer reads line N. Output pixels are unresolved 9-bit palette indices; the mixer performs the palette RAM lookup and layer priority.

## Interface
Parameters:
- `TX_BASE`, default 13'h1000: word base of the text map inside the VRAM export window.
- `WIDTH`, default 448: visible pixels per line.

Ports:
- `fixed_20m_clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `line_start` in 1: one-cycle pulse that starts rendering the line given by `line` and swaps the line buffer banks.
- `line` in 8: screen line to render.
- `scroll_x` in 9: horizontal scroll in pixels, mod 512.
- `scroll_y` in 8: vertical scroll in pixels, mod 256.
- `layer_en` in 1: when 0, forces `pix_out` to 0.
- `vram_addr` out 13: drives `renderer_vram_addr`.
- `vram_dout` in 16: data from VRAM, valid 1 cycle after the address.
- `gfx_addr` out 20: graphics ROM word address.
- `gfx_dout` in 16: graphics ROM data, valid 1 cycle after the address.
- `pix_x` in 9: display-side read x.
- `pix_out` out 9: {palette[4:0], pixel[3:0]}, registered.
- `busy` out 1: high while a line is being rendered.
- `overrun` out 1: one-cycle pulse when `line_start` arrives while `busy` is high.

## Operation
Map layout:
- The map is 64×32 tiles, two words per tile.
- Word 0 is the tile code.
- Word 1 is the attribute: [4:0] palette, [5] flipx, [6] flipy; other bits are ignored.

Per-line setup:
- On `line_start`, latch `y = line + scroll_y` (8-bit wrap), `ty = y[7:3]`, `fy = y[2:0]`, `cx = scroll_x[8:3]`, `fx = scroll_x[2:0]`.
- Toggle the write bank and reset the tile index `i` to 0.

Tile loop, for i = 0..56 with `tx = (cx + i) mod 64` (13 cycles per tile):
- FETCH_CODE: `vram_addr = TX_BASE + {ty, tx, 1'b0}`.
- FETCH_ATTR: `vram_addr = TX_BASE + {ty, tx, 1'b1}`; capture `code` from `vram_dout`.
- FETCH_G0: capture `attr`; `gfx_addr = {code, row, 1'b0}` with `row = fy ^ {3{flipy}}`.
- FETCH_G1: capture `g0`; `gfx_addr = {code, row, 1'b1}`.
- LATCH: capture `g1`.
- DRAW, 8 cycles, p = 0..7:
  - Source pixel index is `s = flipx ? 7-p : p`.
  - Source nibble is `{g1,g0}[4s+3:4s]`; pixel 0 sits in `g0[3:0]`.
  - Screen position is `x = 8i + p - fx`.
  - Write only when `0 ≤ x < WIDTH`.
  - Value written is `{palette, nib}`, or 9'h000 when `nib == 0` (transparent).
- After DRAW p=7: if i = 56, go to IDLE; otherwise increment i and go to FETCH_CODE.

Display side:
- `pix_out <= (layer_en && pix_x < WIDTH) ? dispbank[pix_x] : 0`.
- The display bank is the bank written during the previous line.

Overrun (`line_start` while `busy`):
- Pulse `overrun`.
- Abort the current line; its unwritten pixels keep stale data.
- Swap banks and restart at i=0 for the new line.

Reset:
- FSM goes to IDLE, write bank to 0, `busy` to 0.
- Line buffer contents are not cleared.

## Timing
Reset values of all outputs:
- `vram_addr` = 0, `gfx_addr` = 0, `pix_out` = 0.
- `busy` = 0, `overrun` = 0.

Render timing:
- The first FETCH_CODE is the cycle after `line_start`.
- `busy` is high from that cycle for exactly 741 cycles (57 tiles × 13).
- `line_start` spacing must be ≥ 742 cycles to avoid overrun.
- `vram_addr` and `gfx_addr` hold their last value outside their fetch states.

Read latencies:
- `vram_dout` and `gfx_dout` are sampled exactly 1 cycle after their address is driven.
- `pix_out` has 1-cycle latency from `pix_x`; it is unaffected by rendering in the other bank.

Bank swap: in the `line_start` cycle itself, reads still see the old display bank; from the next cycle they see the new display bank.

## Test plan
1. **Reset.** Assert `reset` mid-DRAW. Required: all outputs 0 immediately; after release, `busy` stays 0 until `line_start`.
2. **Basic tile.**
   - Setup: scroll 0, `line` 0; map entry 0 has code 16'h0005, attr 16'h0003; `gfx[{5,3'd0,0}]` = 16'h4321, `gfx[{5,3'd0,1}]` = 16'h8765.
   - Stimulus: `line_start`, wait 742 cycles, then `line_start` again.
   - Required: `vram_addr` sequence 13'h1000, 13'h1001; `pix_x` 0..7 gives 9'h031..9'h038.
3. **Flips.** Same tile with attr 16'h0063.
   - Required: `gfx_addr` = {5,3'd7,0} then {5,3'd7,1}.
   - Required: `pix_x` 0..7 gives 9'h038..9'h031.
4. **Fine and coarse scroll.**
   - `scroll_x`=3: `pix_x` 0 gives 9'h034, and pixels 445..447 come from tile i=56.
   - `scroll_x`=504: the first fetch is `tx`=63 (`vram_addr` 13'h107E).
5. **Transparency and enable.**
   - A nibble of 0 with palette 3 reads 9'h000.
   - `layer_en`=0 makes every `pix_out` 0.
   - `pix_x`=448 returns 0.
6. **Overrun.** Second `line_start` at cycle 300 of a line.
   - Required: `overrun` high 1 cycle; `vram_addr` returns to the tile 0 address next cycle; `busy` continuously high for 741 more cycles.
